// File: rtl/enigma_step_ctrl_if.sv
// rtl/enigma_step_ctrl_if.sv - byte stream, load and rotor position bundle for enigma_step_ctrl
// o_step_count exists only when ENIGMA_STEP_COUNT_EN is defined.
interface enigma_step_ctrl_if #(
    parameter int NUM_ROTORS = 3
);
    logic                      load;
    logic [NUM_ROTORS*5-1:0]   load_pos;
    logic                      i_valid;
    logic [7:0]                i_data;
    logic                      o_ready;
    logic                      o_valid;
    logic                      i_ready;
    logic [7:0]                o_data;
    logic [4:0]                o_code;
    logic                      o_is_letter;
    logic [NUM_ROTORS*5-1:0]   o_pos;
    logic                      o_load_err;
`ifdef ENIGMA_STEP_COUNT_EN
    logic [31:0]               o_step_count;

    modport slave (
        input  load, load_pos, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_code, o_is_letter, o_pos, o_load_err, o_step_count
    );
    modport master (
        output load, load_pos, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_code, o_is_letter, o_pos, o_load_err, o_step_count
    );
`else
    modport slave (
        input  load, load_pos, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_code, o_is_letter, o_pos, o_load_err
    );
    modport master (
        output load, load_pos, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_code, o_is_letter, o_pos, o_load_err
    );
`endif
endinterface

// File: rtl/enigma_step_ctrl.sv
// rtl/enigma_step_ctrl.sv - N-rotor stepping controller with registered letter/position output
// Optional letter counter output enabled by ENIGMA_STEP_COUNT_EN.
module enigma_step_ctrl #(
    parameter int                      NUM_ROTORS  = 3,
    parameter logic [NUM_ROTORS*5-1:0] NOTCHES     = {5'd16, 5'd4, 5'd21},
    parameter bit                      DOUBLE_STEP = 1'b1
) (
    input  logic              i_clock,
    input  logic              reset,
    enigma_step_ctrl_if.slave bus
);

    logic [NUM_ROTORS*5-1:0] r_pos;
    logic                    r_valid;
    logic [7:0]              r_data;
    logic [4:0]              r_code;
    logic                    r_is_letter;
    logic [NUM_ROTORS*5-1:0] r_out_pos;
    logic                    r_load_err;

    logic                    w_ready;
    logic                    w_xfer_in;
    logic                    w_xfer_out;
    logic                    w_is_upper;
    logic                    w_is_lower;
    logic                    w_is_letter;
    logic [4:0]              w_code;
    logic [NUM_ROTORS-1:0]   w_step;
    logic [NUM_ROTORS-1:0]   w_load_bad;
    logic [NUM_ROTORS*5-1:0] w_next_pos;
    logic [NUM_ROTORS*5-1:0] w_load_clean;

    assign w_ready    = (~r_valid | bus.i_ready) & ~bus.load;
    assign w_xfer_in  = bus.i_valid & w_ready;
    assign w_xfer_out = r_valid & bus.i_ready;

    assign w_is_upper  = (bus.i_data >= 8'h41) && (bus.i_data <= 8'h5A);
    assign w_is_lower  = (bus.i_data >= 8'h61) && (bus.i_data <= 8'h7A);
    assign w_is_letter = w_is_upper | w_is_lower;
    // 'A' and 'a' both have low five bits 5'd1, so one subtract serves both cases.
    assign w_code      = w_is_letter ? (bus.i_data[4:0] - 5'd1) : 5'd0;

    for (genvar k = 0; k < NUM_ROTORS; k++) begin : g_rotor
        logic [4:0] w_cur;
        assign w_cur = r_pos[5*k +: 5];

        if (k == 0) begin : g_fast
            assign w_step[k] = 1'b1;
        end else begin : g_slow
            localparam bit DS = DOUBLE_STEP && (k <= NUM_ROTORS - 2);
            assign w_step[k] = (r_pos[5*(k-1) +: 5] == NOTCHES[5*(k-1) +: 5])
                             | (DS & (w_cur == NOTCHES[5*k +: 5]));
        end

        assign w_next_pos[5*k +: 5]   = !w_step[k]         ? w_cur :
                                        (w_cur == 5'd25)   ? 5'd0  : w_cur + 5'd1;
        assign w_load_bad[k]          = bus.load_pos[5*k +: 5] >= 5'd26;
        assign w_load_clean[5*k +: 5] = w_load_bad[k] ? 5'd0 : bus.load_pos[5*k +: 5];
    end

    always_ff @(posedge i_clock or negedge reset) begin
        if (!reset) begin
            r_pos       <= '0;
            r_valid     <= 1'b0;
            r_data      <= 8'd0;
            r_code      <= 5'd0;
            r_is_letter <= 1'b0;
            r_out_pos   <= '0;
            r_load_err  <= 1'b0;
        end else begin
            if (bus.load) begin
                r_pos <= w_load_clean;
            end else if (w_xfer_in && w_is_letter) begin
                r_pos <= w_next_pos;
            end
            r_load_err <= bus.load & (|w_load_bad);

            if (w_xfer_in) begin
                r_valid     <= 1'b1;
                r_data      <= bus.i_data;
                r_code      <= w_code;
                r_is_letter <= w_is_letter;
                r_out_pos   <= w_is_letter ? w_next_pos : r_pos;
            end else if (w_xfer_out) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef ENIGMA_STEP_COUNT_EN
    logic [31:0] r_step_count;

    always_ff @(posedge i_clock or negedge reset) begin
        if (!reset) begin
            r_step_count <= 32'd0;
        end else if (bus.load) begin
            r_step_count <= 32'd0;
        end else if (w_xfer_in && w_is_letter && (r_step_count != 32'hFFFF_FFFF)) begin
            r_step_count <= r_step_count + 32'd1;
        end
    end

    assign bus.o_step_count = r_step_count;
`endif

    assign bus.o_ready     = w_ready;
    assign bus.o_valid     = r_valid;
    assign bus.o_data      = r_data;
    assign bus.o_code      = r_code;
    assign bus.o_is_letter = r_is_letter;
    assign bus.o_pos       = r_out_pos;
    assign bus.o_load_err  = r_load_err;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// tb/tb_enigma_step_ctrl.sv - directed and randomized checks of enigma_step_ctrl against a rotor model
module tb_enigma_step_ctrl;
    localparam int          NR    = 3;
    localparam logic [14:0] NOTCH = {5'd16, 5'd4, 5'd21};

    logic i_clock = 1'b0;
    logic reset;
    always #5 i_clock = ~i_clock;

    enigma_step_ctrl_if #(.NUM_ROTORS(NR)) bus ();
    enigma_step_ctrl_if #(.NUM_ROTORS(NR)) bus2 ();

    enigma_step_ctrl #(.NUM_ROTORS(NR), .NOTCHES(NOTCH), .DOUBLE_STEP(1'b1)) dut (
        .i_clock(i_clock), .reset(reset), .bus(bus)
    );
    enigma_step_ctrl #(.NUM_ROTORS(NR), .NOTCHES({5'd25, 5'd25, 5'd25}), .DOUBLE_STEP(1'b0)) dut2 (
        .i_clock(i_clock), .reset(reset), .bus(bus2)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          notch [NR] = '{21, 4, 16};
    int          m_pos [NR];
    bit          m_valid;
    logic [7:0]  m_data;
    logic [4:0]  m_code;
    bit          m_letter;
    logic [14:0] m_opos;
    bit          m_err;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] pack_pos();
        logic [14:0] p;
        for (int k = 0; k < NR; k++) p[5*k +: 5] = 5'(m_pos[k]);
        return p;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NR; k++) m_pos[k] = 0;
        m_valid = 0; m_data = 8'd0; m_code = 5'd0; m_letter = 0;
        m_opos = 15'd0; m_err = 0; m_cnt = 32'd0;
    endtask

    // Enigma rule: fast rotor always turns; a rotor turns when its right neighbour
    // sits on its notch, or (double step) when a middle rotor sits on its own notch.
    task automatic m_advance();
        bit st [NR];
        st[0] = 1;
        for (int k = 1; k < NR; k++)
            st[k] = (m_pos[k-1] == notch[k-1]) || (k <= NR - 2 && m_pos[k] == notch[k]);
        for (int k = 0; k < NR; k++)
            if (st[k]) m_pos[k] = (m_pos[k] + 1) % 26;
    endtask

    task automatic drive(input bit ld, input logic [14:0] lp, input bit v, input logic [7:0] d, input bit r);
        bus.load = ld; bus.load_pos = lp; bus.i_valid = v; bus.i_data = d; bus.i_ready = r;
    endtask

    // Compare DUT outputs with the model mid-cycle, then advance the model across one edge.
    task automatic step();
        bit rdy, xin, xout, bad;
        int ci;
        #1;
        rdy = (!m_valid || bus.i_ready) && !bus.load;
        chk("o_ready", bus.o_ready, rdy);
        chk("o_valid", bus.o_valid, m_valid);
        chk("o_load_err", bus.o_load_err, m_err);
        if (m_valid) begin
            chk("o_data", bus.o_data, m_data);
            chk("o_code", bus.o_code, m_code);
            chk("o_is_letter", bus.o_is_letter, m_letter);
            chk("o_pos", bus.o_pos, m_opos);
        end
`ifdef ENIGMA_STEP_COUNT_EN
        chk("o_step_count", bus.o_step_count, m_cnt);
`endif
        xin  = bus.i_valid && rdy;
        xout = m_valid && bus.i_ready;
        m_err = 0;
        if (bus.load) begin
            bad = 0;
            for (int k = 0; k < NR; k++) begin
                int v;
                v = int'(bus.load_pos[5*k +: 5]);
                if (v >= 26) begin v = 0; bad = 1; end
                m_pos[k] = v;
            end
            m_err = bad;
            m_cnt = 32'd0;
        end
        if (xin) begin
            ci = int'(bus.i_data);
            m_data = bus.i_data;
            if (ci >= 65 && ci <= 90)       begin m_letter = 1; m_code = 5'(ci - 65); end
            else if (ci >= 97 && ci <= 122) begin m_letter = 1; m_code = 5'(ci - 97); end
            else                            begin m_letter = 0; m_code = 5'd0; end
            if (m_letter) begin
                m_advance();
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
            m_opos  = pack_pos();
            m_valid = 1;
        end else if (xout) begin
            m_valid = 0;
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        drive(0, 15'd0, 1, c, 1);
        step();
    endtask

    task automatic idle();
        drive(0, 15'd0, 0, 8'd0, 1);
        step();
    endtask

    task automatic ld(input logic [14:0] lp);
        drive(1, lp, 0, 8'd0, 1);
        step();
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 15'd0, 0, 8'd0, 0);
        bus2.load = 0; bus2.load_pos = 15'd0; bus2.i_valid = 0; bus2.i_data = 8'd0; bus2.i_ready = 1;
        m_reset();
        #3;
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_pos", bus.o_pos, 15'd0);
        chk("rst_data", bus.o_data, 8'd0);
        chk("rst_code", bus.o_code, 5'd0);
        chk("rst_letter", bus.o_is_letter, 1'b0);
        chk("rst_load_err", bus.o_load_err, 1'b0);
        @(posedge i_clock);
        #1 reset = 1'b1;

        // Double step: ADU then three letters -> ADV, AEW, BFX
        ld({5'd0, 5'd3, 5'd20});
        send(8'h41); chk("ds1_valid", bus.o_valid, 1'b1); chk("ds1_pos", bus.o_pos, {5'd0, 5'd3, 5'd21});
        send(8'h41); chk("ds2_pos", bus.o_pos, {5'd0, 5'd4, 5'd22});
        send(8'h41); chk("ds3_pos", bus.o_pos, {5'd1, 5'd5, 5'd23});
        idle();

        // Case folding and non-letter pass-through
        ld(15'd0);
        send(8'h62); chk("b_code", bus.o_code, 5'd1);  chk("b_pos", bus.o_pos, {5'd0, 5'd0, 5'd1}); chk("b_data", bus.o_data, 8'h62);
        send(8'h20); chk("sp_code", bus.o_code, 5'd0); chk("sp_let", bus.o_is_letter, 1'b0);  chk("sp_pos", bus.o_pos, {5'd0, 5'd0, 5'd1});
        send(8'h5A); chk("Z_code", bus.o_code, 5'd25); chk("Z_let", bus.o_is_letter, 1'b1);   chk("Z_pos", bus.o_pos, {5'd0, 5'd0, 5'd2});
        idle();

        // Backpressure: stalled entry holds, then full-rate drain
        send(8'h43);
        for (int i = 0; i < 5; i++) begin
            drive(0, 15'd0, 1, 8'h44, 0);
            step();
            chk("bp_ready", bus.o_ready, 1'b0);
            chk("bp_data", bus.o_data, 8'h43);
            chk("bp_pos", bus.o_pos, {5'd0, 5'd0, 5'd3});
        end
        send(8'h44); chk("tp_d_valid", bus.o_valid, 1'b1); chk("tp_d_pos", bus.o_pos, {5'd0, 5'd0, 5'd4});
        send(8'h45); chk("tp_e_valid", bus.o_valid, 1'b1); chk("tp_e_data", bus.o_data, 8'h45);
        idle();

        // Load with an out-of-range slice while a byte is offered
        drive(1, {5'd30, 5'd2, 5'd1}, 1, 8'h46, 1);
        #1 chk("ld_ready", bus.o_ready, 1'b0);
        step();
        chk("ld_err_pulse", bus.o_load_err, 1'b1);
        chk("ld_not_taken", bus.o_valid, 1'b0);
        send(8'h20);
        chk("ld_err_clear", bus.o_load_err, 1'b0);
        chk("ld_pos", bus.o_pos, {5'd0, 5'd2, 5'd1});
        idle();

`ifdef ENIGMA_STEP_COUNT_EN
        ld(15'd0);
        send(8'h41); send(8'h20); send(8'h42); send(8'h20); send(8'h43); send(8'h44);
        chk("cnt_four", bus.o_step_count, 32'd4);
        ld(15'd0);
        chk("cnt_load_clear", bus.o_step_count, 32'd0);
        idle();
`endif

        // Randomized traffic with loads, stalls and mixed bytes
        for (int i = 0; i < 400; i++) begin
            logic [7:0]  d;
            logic [14:0] lp;
            bit          ldr;
            ldr = ($urandom_range(0, 19) == 0);
            lp  = 15'($urandom);
            case ($urandom_range(0, 3))
                0:       d = 8'h41 + 8'($urandom_range(0, 25));
                1:       d = 8'h61 + 8'($urandom_range(0, 25));
                default: d = 8'($urandom);
            endcase
            drive(ldr, lp, $urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0);
            step();
        end
        idle();

        // Asynchronous reset while an entry is pending
        ld({5'd0, 5'd0, 5'd5});
        send(8'h41);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", bus.o_valid, 1'b0);
        chk("arst_pos", bus.o_pos, 15'd0);
        chk("arst_data", bus.o_data, 8'd0);
        m_reset();
        @(posedge i_clock);
        #1 reset = 1'b1;
        send(8'h20);
        chk("arst_rotor_pos", bus.o_pos, 15'd0);
        idle();

        // Wrap of every rotor with single stepping only
        bus2.load = 1; bus2.load_pos = {5'd25, 5'd25, 5'd25};
        @(posedge i_clock);
        #1 bus2.load = 0; bus2.i_valid = 1; bus2.i_data = 8'h41;
        chk("wrap_no_err", bus2.o_load_err, 1'b0);
        @(posedge i_clock);
        #1 bus2.i_valid = 0;
        chk("wrap_valid", bus2.o_valid, 1'b1);
        chk("wrap_pos", bus2.o_pos, 15'd0);
        chk("wrap_code", bus2.o_code, 5'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/enigma_step_ctrl.md
Name: enigma_step_ctrl

Overview:
- Parametrised rotor-stepping controller and character front end for the Enigma datapath.
- Accepts an ASCII byte stream over a valid/ready handshake and steps N rotors per accepted letter, using per-rotor notches with optional double-stepping.
- Presents the post-step rotor positions and the letter code, registered, to the combinational encode chain.
- Replaces fixed three-rotor stepping with a generic N-rotor engine that adds backpressure and pass-through of non-letters.

Parameters:
- NUM_ROTORS, 3, rotor count (1..8); index 0 is the fast (rightmost) rotor.
- NOTCHES, {5'd16,5'd4,5'd21}, packed NUM_ROTORS*5 notch positions; slice [5k+4:5k] is the notch of rotor k (default: rotor0=V, rotor1=E, rotor2=Q).
- DOUBLE_STEP, 1, enables the double-step anomaly for middle rotors.

Ports:
- i_clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  load start positions (1-cycle pulse).
- load_pos  in  NUM_ROTORS*5  start positions, same packing as NOTCHES.
- i_valid  in  1  upstream byte valid.
- i_data  in  8  upstream ASCII byte.
- o_ready  out  1  upstream may transfer.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts the output entry.
- o_data  out  8  original byte, unchanged.
- o_code  out  5  letter index 0..25; 0 for non-letters.
- o_is_letter  out  1  byte was A-Z or a-z.
- o_pos  out  NUM_ROTORS*5  rotor positions to use for this byte.
- o_load_err  out  1  a load value was out of range (1-cycle pulse).

Behaviour:
- Reset (reset=0, async):
  - pos[] cleared to 0.
  - o_valid, o_data, o_code, o_is_letter, o_pos, o_load_err all cleared to 0.
- Internal state: pos[k], 5 bits each; one-entry output register.
- o_ready = (~o_valid | i_ready) & ~load, combinational.
- Transfer in: i_valid & o_ready. Transfer out: o_valid & i_ready.
- Latency: 1 cycle from transfer-in to o_valid.
- Simultaneous out and in in the same cycle sustain full throughput (1 byte/cycle).
- o_valid clears only on transfer-out with no transfer-in.
- All outputs hold stable while o_valid=1 and i_ready=0.
- Letter classification:
  - 'A'..'Z' gives code = byte-65; 'a'..'z' gives code = byte-97.
  - All other bytes: o_is_letter=0, o_code=0.
- Stepping happens on a letter transfer-in, before encode:
  - Conditions are evaluated on pre-step pos[] and all rotors update in the same cycle.
  - rotor0 always steps.
  - rotor k (k>=1) steps if pos[k-1]==notch[k-1].
  - rotor k also steps if DOUBLE_STEP and 1<=k<=NUM_ROTORS-2 and pos[k]==notch[k].
  - Increment wraps 25->0.
- o_pos for a letter carries the new (post-step) positions.
- Non-letter transfer-in: no stepping; o_pos = current pos[]; byte passes through.
- Load:
  - load=1 writes pos[] from load_pos next edge, overriding any stepping and blocking transfer-in that cycle.
  - Any slice >=26 is written as 0 and o_load_err pulses for 1 cycle.
  - The output register is unaffected by load; a pending entry keeps its old o_pos.
- Reset mid-stream: the pending output entry is dropped; pos[] returns to 0.
- NUM_ROTORS=1: only rotor0 exists and it steps on every letter. NUM_ROTORS=2: no double step regardless of DOUBLE_STEP.

Optional Feature:
- Macro: ENIGMA_STEP_COUNT_EN.
- Defined:
  - Adds output o_step_count [31:0], incremented on each letter transfer-in.
  - Cleared to 0 on reset or load; saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Double-step: load {A,D,U}=packed {0,3,20}, send "AAA" with i_ready=1 -> o_pos sequence {0,3,21}, {0,4,22}, {1,5,23} (ADV, AEW, BFX), 1-cycle latency each.
- Case and pass-through: pos {0,0,0}, send 'b', ' ', 'Z' -> o_code 1/0/25; o_is_letter 1/0/1; o_pos {0,0,1}, {0,0,1}, {0,0,2}; o_data 8'h62/8'h20/8'h5A.
- Wrap: load {25,25,25} with DOUBLE_STEP=0, notches {25,25,25}, send 'A' -> o_pos {0,0,0}.
- Backpressure: i_ready=0 with o_valid=1 -> o_ready=0, outputs stable for 5 cycles, pos[] unchanged; i_ready=1 with i_valid=1 -> 1 byte/cycle, no bubble.
- Load edge cases: load_pos {30,2,1} with i_valid=1 on the same cycle -> o_ready=0, byte not taken, pos becomes {0,2,1}, o_load_err pulses once. Assert reset mid-entry -> o_valid=0 and pos 0 immediately (asynchronous).
- With ENIGMA_STEP_COUNT_EN: send 4 letters and 2 spaces -> o_step_count=4; then load -> o_step_count=0.
